// File: rtl/mmio_pkg.sv
// Shared register map for the MMIO responder: register offsets, STATUS bit layout
// and the small decode/pack helpers used by the responder.
package mmio_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TX_W   = 8;

  localparam logic [ADDR_W-1:0] OFF_TXDATA = 12'd0;
  localparam logic [ADDR_W-1:0] OFF_STATUS = 12'd1;
  localparam logic [ADDR_W-1:0] OFF_CYCLE  = 12'd2;

  localparam int unsigned STATUS_FULL_BIT    = 0;
  localparam int unsigned STATUS_EMPTY_BIT   = 1;
  localparam int unsigned STATUS_OVF_BIT     = 2;
  localparam int unsigned STATUS_COUNT_LSB   = 3;
  localparam int unsigned STATUS_COUNT_W     = 3;
  localparam int unsigned STATUS_CLR_OVF_BIT = 2;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_NONE   = 2'd3
  } mmio_reg_e;

  function automatic mmio_reg_e decodeReg(input logic isMmio, input logic [ADDR_W-1:0] offset);
    mmio_reg_e sel;
    sel = REG_NONE;
    if (isMmio) begin
      if (offset == OFF_TXDATA)      sel = REG_TXDATA;
      else if (offset == OFF_STATUS) sel = REG_STATUS;
      else if (offset == OFF_CYCLE)  sel = REG_CYCLE;
      else                           sel = REG_NONE;
    end
    return sel;
  endfunction

  // Deep FIFOs report a pinned-at-max count rather than a wrapped one.
  function automatic logic [STATUS_COUNT_W-1:0] satCount(input logic [31:0] count);
    logic [STATUS_COUNT_W-1:0] result;
    if (count > 32'd7) result = '1;
    else               result = count[STATUS_COUNT_W-1:0];
    return result;
  endfunction

  function automatic logic [DATA_W-1:0] packStatus(
    input logic [STATUS_COUNT_W-1:0] count,
    input logic                      overflow,
    input logic                      empty,
    input logic                      full
  );
    logic [DATA_W-1:0] status;
    status                                        = '0;
    status[STATUS_FULL_BIT]                       = full;
    status[STATUS_EMPTY_BIT]                      = empty;
    status[STATUS_OVF_BIT]                        = overflow;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W]    = count;
    return status;
  endfunction

endpackage

// File: rtl/mmio_responder_tx_fifo.sv
// Byte FIFO feeding the TX stream; head entry is presented straight from storage,
// so a freshly pushed byte only becomes visible after the clock edge.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8,
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_headData
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_doPop;
  logic w_doPush;

  assign o_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_headData = o_empty ? '0 : r_mem[r_rdPtr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] result;
    if (ptr == PTR_W'(FIFO_DEPTH - 1)) result = '0;
    else                               result = ptr + PTR_W'(1);
    return result;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset && w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      unique case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Data-memory front end: passes loads/stores to RAM below MMIO_BASE and serves
// TXDATA/STATUS/CYCLE registers above it, with a uniform one-cycle load latency.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MMIO_BASE  = 12'hF00,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tx_valid,
  output logic [TX_W-1:0]   tx_data,
  input  logic              tx_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              w_isMmio;
  logic [ADDR_W-1:0] w_offset;
  mmio_reg_e         w_reg;
  logic              w_txWrite;
  logic              w_statusWrite;
  logic              w_cycleWrite;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [TX_W-1:0]   w_head;
  logic              w_ovfSet;
  logic              w_ovfClear;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_mmioRdata;

  logic              r_isMmio;
  logic [DATA_W-1:0] r_mmioRdata;
  logic              r_overflow;
  logic [DATA_W-1:0] r_cycle;

  assign w_isMmio = (address_dmem >= MMIO_BASE);
  assign w_offset = address_dmem - MMIO_BASE;
  assign w_reg    = decodeReg(w_isMmio, w_offset);

  assign ram_address = address_dmem;
  assign ram_data    = data;
  assign ram_wren    = wren && !w_isMmio;

  assign w_txWrite     = wren && (w_reg == REG_TXDATA);
  assign w_statusWrite = wren && (w_reg == REG_STATUS);
  assign w_cycleWrite  = wren && (w_reg == REG_CYCLE);

  assign tx_valid = !w_empty;
  assign tx_data  = w_head;
  assign w_pop    = tx_valid && tx_ready;

  tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (TX_W)
  ) u_txFifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_txWrite),
    .i_pushData (data[TX_W-1:0]),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_headData (w_head)
  );

  assign w_ovfSet   = w_txWrite && w_full && !w_pop;
  assign w_ovfClear = w_statusWrite && data[STATUS_CLR_OVF_BIT];
  assign w_status   = packStatus(satCount(32'(w_count)), r_overflow, w_empty, w_full);

  // Register reads see state as it stands in the request cycle, before this edge's updates.
  always_comb begin
    w_mmioRdata = '0;
    unique case (w_reg)
      REG_STATUS: w_mmioRdata = w_status;
      REG_CYCLE:  w_mmioRdata = r_cycle;
      default:    w_mmioRdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_isMmio    <= 1'b0;
      r_mmioRdata <= '0;
      r_overflow  <= 1'b0;
      r_cycle     <= '0;
    end else begin
      r_isMmio    <= w_isMmio;
      r_mmioRdata <= w_mmioRdata;
      if (w_ovfSet)        r_overflow <= 1'b1;
      else if (w_ovfClear) r_overflow <= 1'b0;
      if (w_cycleWrite) r_cycle <= data;
      else              r_cycle <= r_cycle + 32'd1;
    end
  end

  assign q_dmem = r_isMmio ? r_mmioRdata : ram_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: stimulus predicts responses from a queue-based
// model of the register map, a negedge monitor compares them against the DUT.
module tb_mmio_responder;

  localparam logic [11:0] BASE  = 12'hF00;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [11:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q = '0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  mmio_responder #(
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  always #5 clock = ~clock;

  // Synchronous RAM with read-old-data behaviour on a same-cycle write.
  logic [31:0] ramMem [0:4095];
  always @(posedge clock) begin
    if (ram_wren) ramMem[ram_address] <= ram_data;
    ram_q <= ramMem[ram_address];
  end

  typedef struct {
    int          due;
    bit          isQ;
    logic [31:0] expQ;
    bit          chkTx;
    logic        expValid;
    logic [7:0]  expData;
    logic        expWren;
    logic [11:0] expAddr;
    logic [31:0] expRamData;
  } item_t;

  item_t       sb[$];
  logic [7:0]  expBytes[$];
  logic [7:0]  mFifo[$];
  logic        mOvf = 1'b0;
  logic [31:0] mCycle = '0;
  logic [31:0] ramRef[int];
  bit          known = 0;
  int          curCycle = 0;
  int          errors = 0;
  int          checks = 0;
  item_t       monItem;
  logic [7:0]  monByte;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, curCycle, act, exp);
    end
  endtask

  task automatic checkOutput(input item_t it);
    if (it.isQ) begin
      checkVal("q_dmem", q_dmem, it.expQ);
    end else begin
      checkVal("ram_wren", {31'b0, ram_wren}, {31'b0, it.expWren});
      checkVal("ram_address", {20'b0, ram_address}, {20'b0, it.expAddr});
      checkVal("ram_data", ram_data, it.expRamData);
      if (it.chkTx) begin
        checkVal("tx_valid", {31'b0, tx_valid}, {31'b0, it.expValid});
        if (it.expValid) checkVal("tx_data_head", {24'b0, tx_data}, {24'b0, it.expData});
      end
    end
  endtask

  // One cycle of stimulus: predict the outputs, queue them, then advance the model.
  task automatic applyStimulus(input logic rst, input logic [11:0] addr, input logic [31:0] dat,
                               input logic we, input logic rdy, input bit useLit,
                               input logic [31:0] lit);
    item_t       it;
    logic [31:0] rd;
    bit          rdKnown;
    bit          isM;
    int          off;
    int          cnt;
    bit          popNow;
    bit          pushReq;
    bit          setOvf;
    @(posedge clock);
    #1;
    curCycle++;
    reset        = rst;
    address_dmem = addr;
    data         = dat;
    wren         = we;
    tx_ready     = rdy;

    isM     = (addr >= BASE);
    off     = int'(addr) - int'(BASE);
    cnt     = mFifo.size();
    rd      = '0;
    rdKnown = 1;
    if (!isM || rst) begin
      rdKnown = ramRef.exists(int'(addr));
      rd      = rdKnown ? ramRef[int'(addr)] : 32'h0;
    end else begin
      rdKnown = known;
      if (off == 1)      rd = (((cnt > 7) ? 32'd7 : 32'(cnt)) * 8) + (mOvf ? 32'd4 : 32'd0)
                              + ((cnt == 0) ? 32'd2 : 32'd0) + ((cnt == DEPTH) ? 32'd1 : 32'd0);
      else if (off == 2) rd = mCycle;
      else               rd = 32'h0;
    end
    if (useLit) begin
      rd      = lit;
      rdKnown = 1;
    end

    it = '{default: 0};
    it.due        = curCycle;
    it.isQ        = 0;
    it.chkTx      = known;
    it.expValid   = (cnt > 0);
    it.expData    = (cnt > 0) ? mFifo[0] : 8'h0;
    it.expWren    = we && !isM;
    it.expAddr    = addr;
    it.expRamData = dat;
    sb.push_back(it);
    if (rdKnown) begin
      it      = '{default: 0};
      it.due  = curCycle + 1;
      it.isQ  = 1;
      it.expQ = rd;
      sb.push_back(it);
    end

    if (rst) begin
      mFifo.delete();
      expBytes.delete();
      mOvf   = 1'b0;
      mCycle = 32'h0;
      known  = 1;
    end else if (known) begin
      popNow  = (cnt > 0) && rdy;
      pushReq = we && isM && (off == 0);
      setOvf  = 0;
      if (popNow) void'(mFifo.pop_front());
      if (pushReq) begin
        if (cnt == DEPTH && !popNow) setOvf = 1;
        else begin
          mFifo.push_back(dat[7:0]);
          expBytes.push_back(dat[7:0]);
        end
      end
      if (we && isM && off == 1 && dat[2]) mOvf = 1'b0;
      if (setOvf) mOvf = 1'b1;
      mCycle = (we && isM && off == 2) ? dat : mCycle + 32'd1;
    end
    if (we && !isM) ramRef[int'(addr)] = dat;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 12'h0, 32'h0, 1'b0, rdy, 0, 32'h0);
  endtask

  // Monitor: drains due predictions and checks every accepted TX byte in order.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= curCycle) begin
      monItem = sb.pop_front();
      checkOutput(monItem);
    end
    if (known && tx_valid && tx_ready && !reset) begin
      if (expBytes.size() == 0) begin
        checkVal("tx_unexpected_byte", {24'b0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        monByte = expBytes.pop_front();
        checkVal("tx_byte", {24'b0, tx_data}, {24'b0, monByte});
      end
    end
  end

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic        we;
    logic        rdy;
    logic        rst;
    int          sel;

    applyStimulus(1, 12'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 12'h0, 32'h0, 0, 0, 0, 0);

    // Two queued bytes, head visible, STATUS count 2.
    applyStimulus(0, BASE, 32'h41, 1, 0, 0, 0);
    applyStimulus(0, BASE, 32'h42, 1, 0, 0, 0);
    applyStimulus(0, BASE + 12'd1, 32'h0, 0, 0, 1, 32'h10);

    // Overflow on the fifth byte, then clear it through STATUS.
    applyStimulus(1, 12'h0, 32'h0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, BASE, 32'h50 + 32'(i), 1, 0, 0, 0);
    applyStimulus(0, BASE + 12'd1, 32'h0, 0, 0, 1, 32'h25);
    applyStimulus(0, BASE + 12'd1, 32'h4, 1, 0, 0, 0);
    applyStimulus(0, BASE + 12'd1, 32'h0, 0, 0, 1, 32'h21);

    // Push while full and popping is accepted.
    applyStimulus(0, BASE, 32'h77, 1, 1, 0, 0);
    applyStimulus(0, BASE + 12'd1, 32'h0, 0, 0, 1, 32'h21);
    repeat (5) idle(1);
    applyStimulus(0, BASE + 12'd1, 32'h0, 0, 0, 1, 32'h2);

    // CYCLE load then wrap.
    applyStimulus(0, BASE + 12'd2, 32'hFFFF_FFFE, 1, 0, 0, 0);
    applyStimulus(0, BASE + 12'd2, 32'h0, 0, 0, 1, 32'hFFFF_FFFE);
    idle(0);
    applyStimulus(0, BASE + 12'd2, 32'h0, 0, 0, 1, 32'h0);

    // RAM store/load and MMIO stores that must not reach RAM.
    applyStimulus(0, 12'h010, 32'hDEAD_BEEF, 1, 0, 0, 0);
    applyStimulus(0, 12'h010, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(0, BASE + 12'd5, 32'h1234_5678, 1, 0, 0, 0);
    applyStimulus(0, BASE + 12'd5, 32'h0, 0, 0, 1, 32'h0);
    applyStimulus(0, BASE, 32'h0000_0099, 1, 0, 0, 0);

    // Reset with bytes pending discards them and restarts CYCLE.
    applyStimulus(0, BASE, 32'h61, 1, 0, 0, 0);
    applyStimulus(0, BASE, 32'h62, 1, 0, 0, 0);
    applyStimulus(1, BASE + 12'd1, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, BASE + 12'd1, 32'h0, 0, 0, 1, 32'h2);
    applyStimulus(0, BASE + 12'd2, 32'h0, 0, 0, 1, 32'h1);

    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = 12'($urandom_range(0, 15));
        3, 4:    a = BASE;
        5:       a = BASE + 12'd1;
        6:       a = BASE + 12'd2;
        7:       a = BASE + 12'($urandom_range(3, 255));
        8:       a = 12'($urandom_range(16, 3839));
        default: a = 12'hFFF;
      endcase
      d   = $urandom;
      we  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 79) == 0);
      if (((n / 100) % 2) == 0) rdy = ($urandom_range(0, 7) == 0);
      else                      rdy = ($urandom_range(0, 2) != 0);
      if (rst) rdy = 1'b0;
      applyStimulus(rst, a, d, we, rdy, 0, 0);
    end

    repeat (3) idle(0);
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
